sync_bus_arbiter: RTL and testbench

//  Source-domain scheduler for a shared multi-bit synchronizer bus. Round-robin arbitrates

---
 rtl/sync_bus_arbiter.sv | 111 +++++++++++
 tb/tb_sync_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_bus_arbiter.sv
// Source-domain scheduler for a shared synchronizer bus: round-robin grant, registered word,
// then a fixed-length enable pulse followed by an idle gap before the next grant.
module sync_bus_arbiter #(
  parameter int BusWidth   = 8,
  parameter int NumReq     = 4,
  parameter int HoldCycles = 4,
  parameter int IdleGap    = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumReq-1:0]          req_valid_i,
  input  logic [NumReq*BusWidth-1:0] req_data_i,
  output logic [NumReq-1:0]          req_ready_o,
  output logic [BusWidth-1:0]        unsync_bus_o,
  output logic                       sync_en_o,
  output logic [$clog2(NumReq)-1:0]  grant_id_o,
  output logic                       busy_o
);

  localparam int IdW    = $clog2(NumReq);
  localparam int MaxCnt = (HoldCycles > IdleGap) ? HoldCycles : IdleGap;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HoldCycles - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'(IdleGap - 1);
  localparam logic [IdW-1:0]  PtrRst   = IdW'(NumReq - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state_q;
  logic [IdW-1:0]       ptr_q;
  logic [CntW-1:0]      cnt_q;
  logic [BusWidth-1:0]  unsync_bus_q;
  logic                 sync_en_q;
  logic [IdW-1:0]       grant_q;
  logic [IdW-1:0]       win_idx;
  logic                 any_req;

  // Descending scan so the candidate closest after the pointer is the last one written.
  always_comb begin
    win_idx = '0;
    any_req = 1'b0;
    for (int k = NumReq; k >= 1; k--) begin
      if (req_valid_i[(int'(ptr_q) + k) % NumReq]) begin
        win_idx = IdW'((int'(ptr_q) + k) % NumReq);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (state_q == S_IDLE && any_req && !rst_i) begin
      req_ready_o[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      ptr_q        <= PtrRst;
      cnt_q        <= '0;
      unsync_bus_q <= '0;
      sync_en_q    <= 1'b0;
      grant_q      <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (any_req) begin
            unsync_bus_q <= req_data_i[int'(win_idx)*BusWidth +: BusWidth];
            grant_q      <= win_idx;
            ptr_q        <= win_idx;
            state_q      <= S_SETUP;
          end
        end
        S_SETUP: begin
          sync_en_q <= 1'b1;
          cnt_q     <= HoldLoad;
          state_q   <= S_HOLD;
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            sync_en_q <= 1'b0;
            cnt_q     <= GapLoad;
            state_q   <= S_GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign unsync_bus_o = unsync_bus_q;
  assign sync_en_o    = sync_en_q;
  assign grant_id_o   = grant_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sync_bus_arbiter.sv
// Directed bench for sync_bus_arbiter: hand-computed grant order, pulse timing and reset abort,
// plus a per-cycle monitor on bus stability and ready one-hotness.
module tb_sync_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [3:0]  req_valid_i = '0;
  logic [31:0] req_data_i = '0;
  logic [3:0]  req_ready_o;
  logic [7:0]  unsync_bus_o;
  logic        sync_en_o;
  logic [1:0]  grant_id_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  logic [7:0] prev_bus;

  sync_bus_arbiter #(.BusWidth(8), .NumReq(4), .HoldCycles(4), .IdleGap(1)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_data_i   (req_data_i),
    .req_ready_o  (req_ready_o),
    .unsync_bus_o (unsync_bus_o),
    .sync_en_o    (sync_en_o),
    .grant_id_o   (grant_id_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (chk_en) begin
      n_checks++;
      if (sync_en_o && unsync_bus_o !== prev_bus) begin
        n_errors++;
        $display("FAIL bus_stable: bus=%h previous=%h while enable high", unsync_bus_o, prev_bus);
      end
      n_checks++;
      if (!$onehot0(req_ready_o) || (req_ready_o !== 4'b0000 && busy_o !== 1'b0)) begin
        n_errors++;
        $display("FAIL ready_onehot_idle: ready=%b busy=%b, need one-hot/zero and only when idle",
                 req_ready_o, busy_o);
      end
    end
    prev_bus = unsync_bus_o;
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset;
    rst_i = 1'b1;
    req_valid_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset;
    req_data_i = '0;
    do_reset();
    chk_en = 1'b1;
    n_checks++;
    if ({unsync_bus_o, sync_en_o, grant_id_o, busy_o, req_ready_o} !== 16'h0000) begin
      n_errors++;
      $display("FAIL reset_state: bus=%h en=%b gid=%0d busy=%b ready=%b, required all zero",
               unsync_bus_o, sync_en_o, grant_id_o, busy_o, req_ready_o);
    end
  endtask

  task automatic test_single_transfer;
    req_data_i = 32'h0000_00A5;
    req_valid_i = 4'b0001;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL single_ready: got %b, required 0001", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    n_checks++;
    if (unsync_bus_o !== 8'hA5 || sync_en_o !== 1'b0 || busy_o !== 1'b1 || grant_id_o !== 2'd0) begin
      n_errors++;
      $display("FAIL single_setup: bus=%h en=%b busy=%b gid=%0d, required A5 0 1 0",
               unsync_bus_o, sync_en_o, busy_o, grant_id_o);
    end
    for (int c = 2; c <= 5; c++) begin
      tick();
      n_checks++;
      if (sync_en_o !== 1'b1 || unsync_bus_o !== 8'hA5) begin
        n_errors++;
        $display("FAIL single_hold c%0d: en=%b bus=%h, required 1 A5", c, sync_en_o, unsync_bus_o);
      end
    end
    tick();
    n_checks++;
    if (sync_en_o !== 1'b0 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL single_gap: en=%b busy=%b, required 0 1", sync_en_o, busy_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || req_ready_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL single_idle: busy=%b ready=%b, required 0 0000", busy_o, req_ready_o);
    end
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || unsync_bus_o !== 8'hA5 || grant_id_o !== 2'd0) begin
      n_errors++;
      $display("FAIL single_hold_outputs: busy=%b bus=%h gid=%0d, required 0 A5 0",
               busy_o, unsync_bus_o, grant_id_o);
    end
  endtask

  task automatic test_round_robin;
    int         order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [3:0] exp_ready;
    do_reset();
    req_data_i = {words[3], words[2], words[1], words[0]};
    req_valid_i = 4'b1111;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_ready = 4'b0001 << order[g];
      n_checks++;
      if (req_ready_o !== exp_ready) begin
        n_errors++;
        $display("FAIL rr_ready g%0d: got %b, required %b", g, req_ready_o, exp_ready);
      end
      tick();
      n_checks++;
      if (grant_id_o !== 2'(order[g]) || unsync_bus_o !== words[order[g]]) begin
        n_errors++;
        $display("FAIL rr_grant g%0d: gid=%0d bus=%h, required %0d %h",
                 g, grant_id_o, unsync_bus_o, order[g], words[order[g]]);
      end
      repeat (6) tick();
      n_checks++;
      if (busy_o !== 1'b0) begin
        n_errors++;
        $display("FAIL rr_period g%0d: busy=%b seven cycles after accept, required 0", g, busy_o);
      end
    end
    req_valid_i = '0;
    repeat (8) tick();
  endtask

  task automatic test_wrap;
    do_reset();
    req_data_i = 32'h4433_2211;
    req_valid_i = 4'b0100;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0100) begin
      n_errors++;
      $display("FAIL wrap_first_ready: got %b, required 0100", req_ready_o);
    end
    tick();
    req_valid_i = 4'b0101;
    n_checks++;
    if (grant_id_o !== 2'd2 || unsync_bus_o !== 8'h33) begin
      n_errors++;
      $display("FAIL wrap_first_grant: gid=%0d bus=%h, required 2 33", grant_id_o, unsync_bus_o);
    end
    repeat (6) tick();
    n_checks++;
    if (req_ready_o !== 4'b0001) begin
      n_errors++;
      $display("FAIL wrap_second_ready: got %b, required 0001", req_ready_o);
    end
    tick();
    n_checks++;
    if (grant_id_o !== 2'd0 || unsync_bus_o !== 8'h11) begin
      n_errors++;
      $display("FAIL wrap_second_grant: gid=%0d bus=%h, required 0 11", grant_id_o, unsync_bus_o);
    end
    repeat (6) tick();
    n_checks++;
    if (req_ready_o !== 4'b0100) begin
      n_errors++;
      $display("FAIL wrap_third_ready: got %b, required 0100", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    n_checks++;
    if (grant_id_o !== 2'd2 || unsync_bus_o !== 8'h33) begin
      n_errors++;
      $display("FAIL wrap_third_grant: gid=%0d bus=%h, required 2 33", grant_id_o, unsync_bus_o);
    end
    repeat (7) tick();
  endtask

  task automatic test_reset_abort;
    do_reset();
    req_data_i = 32'h0000_775A;
    req_valid_i = 4'b0001;
    #1;
    tick();
    req_valid_i = 4'b0010;
    tick();
    tick();
    n_checks++;
    if (sync_en_o !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_pre_hold: en=%b, required 1", sync_en_o);
    end
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (sync_en_o !== 1'b0 || unsync_bus_o !== 8'h00 || busy_o !== 1'b0 ||
        grant_id_o !== 2'd0 || req_ready_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL abort_reset: en=%b bus=%h busy=%b gid=%0d ready=%b, required all zero",
               sync_en_o, unsync_bus_o, busy_o, grant_id_o, req_ready_o);
    end
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0010) begin
      n_errors++;
      $display("FAIL abort_pending_ready: got %b, required 0010", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    n_checks++;
    if (grant_id_o !== 2'd1 || unsync_bus_o !== 8'h77 || busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_pending_grant: gid=%0d bus=%h busy=%b, required 1 77 1",
               grant_id_o, unsync_bus_o, busy_o);
    end
    repeat (6) tick();
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_done: busy=%b, required 0", busy_o);
    end
  endtask

  task automatic test_ignored_pulse;
    do_reset();
    req_data_i = 32'hEE00_00C3;
    req_valid_i = 4'b0001;
    #1;
    tick();
    req_valid_i = '0;
    tick();
    req_valid_i = 4'b1000;
    #1;
    n_checks++;
    if (req_ready_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL pulse_ready_busy: got %b, required 0000", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    repeat (5) tick();
    n_checks++;
    if (busy_o !== 1'b0 || grant_id_o !== 2'd0 || unsync_bus_o !== 8'hC3 || req_ready_o !== 4'b0000) begin
      n_errors++;
      $display("FAIL pulse_idle: busy=%b gid=%0d bus=%h ready=%b, required 0 0 C3 0000",
               busy_o, grant_id_o, unsync_bus_o, req_ready_o);
    end
    repeat (3) tick();
    n_checks++;
    if (busy_o !== 1'b0 || unsync_bus_o !== 8'hC3) begin
      n_errors++;
      $display("FAIL pulse_never_granted: busy=%b bus=%h, required 0 C3", busy_o, unsync_bus_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_transfer();
    test_round_robin();
    test_wrap();
    test_reset_abort();
    test_ignored_pulse();
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
